// File: rtl/approx_adder_pipe_pkg.sv
// approx_adder_pipe_pkg: shared mode encoding and default sizing for the approximate adder pipeline.
package approx_adder_pipe_pkg;
  typedef enum logic {EXACT = 1'b0, APPROX = 1'b1} mode_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_APPROX_BITS = 4;
  localparam int DEF_ERR_W = 16;
endpackage

// File: rtl/loa_core.sv
// loa_core: combinational lower-part-OR adder with exact bypass and absolute error versus the exact sum.
module loa_core
  import approx_adder_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mode_e            mode,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH:0]   err
);
  logic [WIDTH:0] exact, approx;
  assign exact = {1'b0, a} + {1'b0, b};
  generate
    if (APPROX_BITS == 0) begin : g_exact
      assign approx = exact;
    end else if (APPROX_BITS >= WIDTH) begin : g_all_or
      assign approx = {a[WIDTH-1] & b[WIDTH-1], a | b};
    end else begin : g_loa
      localparam int K = APPROX_BITS;
      logic [WIDTH-K:0] hi;
      // the top OR'd bit pair stands in for the carry the low part would have produced
      assign hi = {1'b0, a[WIDTH-1:K]} + {1'b0, b[WIDTH-1:K]} + {{(WIDTH-K){1'b0}}, a[K-1] & b[K-1]};
      assign approx = {hi, a[K-1:0] | b[K-1:0]};
    end
  endgenerate
  always_comb begin
    {cout, sum} = (mode == APPROX) ? approx : exact;
    err = (mode != APPROX) ? '0 : (exact > approx) ? exact - approx : approx - exact;
  end
endmodule

// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: two-stage valid/ready pipeline around loa_core with saturating error statistics.
module approx_adder_pipe
  import approx_adder_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in1,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  input  logic               clr_stats,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [ERR_W-1:0]   err_sum
);
  localparam int AW = ((ERR_W > WIDTH + 1) ? ERR_W : WIDTH + 1) + 1;
  localparam logic [AW-1:0] SAT = AW'({ERR_W{1'b1}});
  logic s1_valid, s2_load, accept, done;
  logic [WIDTH-1:0] s1_a, s1_b, c_sum;
  mode_e s1_mode;
  logic c_cout;
  logic [WIDTH:0] c_err, s2_err;
  logic [AW-1:0] acc;
  logic [ERR_W-1:0] cnt_nx, sum_nx;
  assign s2_load = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_load);
  assign accept = in_valid && in_ready;
  assign done = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_mode <= EXACT;
    end else begin
      if (s2_load || !s1_valid) s1_valid <= accept;
      if (accept) begin
        s1_a <= in1[WIDTH-1:0];
        s1_b <= in1[2*WIDTH-1:WIDTH];
        s1_mode <= mode_e'(mode);
      end
    end
  end
  loa_core #(.WIDTH(WIDTH), .APPROX_BITS(APPROX_BITS)) u_core (
    .a(s1_a),
    .b(s1_b),
    .mode(s1_mode),
    .sum(c_sum),
    .cout(c_cout),
    .err(c_err)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      s2_err <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum <= c_sum;
        cout <= c_cout;
        s2_err <= c_err;
      end
    end
  end
  always_comb begin
    acc = AW'(err_sum) + AW'(s2_err);
    sum_nx = (acc > SAT) ? '1 : acc[ERR_W-1:0];
    cnt_nx = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      err_sum <= '0;
    end else if (clr_stats) begin
      err_cnt <= '0;
      err_sum <= '0;
    end else if (done && s2_err != '0) begin
      err_cnt <= cnt_nx;
      err_sum <= sum_nx;
    end
  end
endmodule

// File: tb/tb_approx_adder_pipe.sv
// tb_approx_adder_pipe: directed-vector bench for approx_adder_pipe at WIDTH=8, APPROX_BITS=4.
module tb_approx_adder_pipe;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b1, clr_stats = 1'b0;
  logic [2*W-1:0] in1 = '0;
  logic in_ready, out_valid, cout, in_ready4, out_valid4, cout4;
  logic [W-1:0] sum, sum4;
  logic [15:0] err_cnt, err_sum;
  logic [3:0] err_cnt4, err_sum4;
  approx_adder_pipe #(.WIDTH(W), .APPROX_BITS(4), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .clr_stats(clr_stats), .err_cnt(err_cnt), .err_sum(err_sum)
  );
  approx_adder_pipe #(.WIDTH(W), .APPROX_BITS(4), .ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in1(in1), .mode(mode),
    .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4), .cout(cout4),
    .clr_stats(clr_stats), .err_cnt(err_cnt4), .err_sum(err_sum4)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic [7:0] s;
    logic       c;
    logic [8:0] e;
  } vec_t;
  vec_t vt[11];
  vec_t sv[4];
  int n_cmp = 0, n_fail = 0, m_cnt = 0, m_sum = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model(input vec_t v, input bit clr);
    if (clr) begin
      m_cnt = 0;
      m_sum = 0;
    end else if (v.e != 0) begin
      m_cnt++;
      m_sum += int'(v.e);
    end
  endtask
  task automatic send(input vec_t v, input bit clr);
    @(negedge clk);
    in_valid = 1'b1;
    in1 = {v.b, v.a};
    mode = v.m;
    #1 chk("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat1_out_valid", out_valid, 0);
    @(negedge clk);
    clr_stats = clr;
    #1 chk("lat2_out_valid", out_valid, 1);
    chk("sum", sum, v.s);
    chk("cout", cout, v.c);
    model(v, clr);
    @(negedge clk);
    clr_stats = 1'b0;
    #1 chk("out_valid_drop", out_valid, 0);
    chk("err_cnt", err_cnt, m_cnt);
    chk("err_sum", err_sum, m_sum);
  endtask
  initial begin
    int sent, recv;
    bit acc;
    vt[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 9'd0};
    vt[1]  = '{8'h0F, 8'h01, 1'b1, 8'h0F, 1'b0, 9'd1};
    vt[2]  = '{8'h88, 8'h88, 1'b1, 8'h18, 1'b1, 9'd8};
    vt[3]  = '{8'h88, 8'h88, 1'b0, 8'h10, 1'b1, 9'd0};
    vt[4]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 9'd0};
    vt[5]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 9'd1};
    vt[6]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 9'd0};
    vt[7]  = '{8'h05, 8'h0A, 1'b1, 8'h0F, 1'b0, 9'd0};
    vt[8]  = '{8'h37, 8'h29, 1'b1, 8'h5F, 1'b0, 9'd1};
    vt[9]  = '{8'h0C, 8'h04, 1'b1, 8'h0C, 1'b0, 9'd4};
    vt[10] = '{8'hF8, 8'h08, 1'b1, 8'h08, 1'b1, 9'd8};
    repeat (2) @(negedge clk);
    #1 chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_sum", err_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 11; i++) send(vt[i], 1'b0);
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    m_cnt = 0;
    m_sum = 0;
    #1 chk("clr_err_cnt", err_cnt, 0);
    chk("clr_err_sum", err_sum, 0);
    repeat (3) send(vt[2], 1'b0);
    chk("sat_err_cnt4", err_cnt4, 3);
    chk("sat_err_sum4", err_sum4, 15);
    send(vt[2], 1'b1);
    chk("clr_prio_err_cnt4", err_cnt4, 0);
    chk("clr_prio_err_sum4", err_sum4, 0);
    sv[0] = vt[1];
    sv[1] = vt[2];
    sv[2] = vt[4];
    sv[3] = vt[5];
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid = (sent < 4);
      if (sent < 4) begin
        in1 = {sv[sent].b, sv[sent].a};
        mode = sv[sent].m;
      end
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_sum", sum, sv[0].s);
        chk("stall_cout", cout, sv[0].c);
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("stream_sum", sum, sv[recv].s);
        chk("stream_cout", cout, sv[recv].c);
        model(sv[recv], 1'b0);
        recv++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", sent, 4);
    chk("stream_recv", recv, 4);
    @(negedge clk);
    #1 chk("stream_no_dup", out_valid, 0);
    chk("stream_err_cnt", err_cnt, m_cnt);
    chk("stream_err_sum", err_sum, m_sum);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in1 = {vt[0].b, vt[0].a};
    mode = vt[0].m;
    @(negedge clk);
    in1 = {vt[3].b, vt[3].a};
    mode = vt[3].m;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("inflight_out_valid", out_valid, 1);
    rst = 1'b1;
    #1 chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("midrst_release_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 chk("stale_out_valid", out_valid, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
